ex_muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer that sits beside the execute-stage ALU.
- It accepts M-extension ops with the already-forwarded operands and runs a radix-2 shift-add or restoring-divide loop.
- While busy it holds the ID/EX and IF/ID registers via a stall output, then presents one result for the EX/MEM register to capture.

---
 rtl/ex_muldiv_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with a sign fix-up cycle.
`timescale 1ns/1ps
module ex_muldiv_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_flush,
   output logic                  o_stall_e,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int W = DATA_WIDTH;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [2:0]           op_q;
   logic [W-1:0]         a_mag_q, b_mag_q;
   logic                 neg_q, spec_q;
   logic [2*W-1:0]       acc_q;

   logic                 sign_a, sign_b, a_neg, b_neg, res_neg;
   logic                 b_zero, div_ovf, special;
   logic [W-1:0]         a_abs, b_abs, special_val;
   logic [W:0]           mul_add, rem_sh, diff;
   logic [2*W-1:0]       mul_next, div_next, prod;
   logic [W-1:0]         quot, rem, fix_val;

   // Operand decode on the forwarded values, used only on the accepting edge.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
      case (i_op)
         OP_MULH, OP_DIV, OP_REM: begin
            sign_a = 1'b1;
            sign_b = 1'b1;
         end
         OP_MULHSU: sign_a = 1'b1;
         default: ;
      endcase
      a_neg   = sign_a & i_a[W-1];
      b_neg   = sign_b & i_b[W-1];
      a_abs   = a_neg ? (~i_a + 1'b1) : i_a;
      b_abs   = b_neg ? (~i_b + 1'b1) : i_b;
      res_neg = (i_op[2] & i_op[1]) ? a_neg : (a_neg ^ b_neg);
      b_zero  = (i_b == '0);
      div_ovf = ~i_op[0] & (i_a == MIN_INT) & (&i_b);
      special = i_op[2] & (b_zero | div_ovf);
      if (b_zero) special_val = i_op[1] ? i_a : '1;
      else        special_val = i_op[1] ? '0 : MIN_INT;
   end

   // One loop step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_add  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
      mul_next = {mul_add, acc_q[W-1:1]};
      rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
      diff     = rem_sh - {1'b0, b_mag_q};
      if (!diff[W]) div_next = {diff[W-1:0], acc_q[W-2:0], 1'b1};
      else          div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
   end

   // Sign fix-up: the product is negated as a whole so MULH* high halves come out right.
   always_comb begin
      prod = neg_q ? (~acc_q + 1'b1) : acc_q;
      quot = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
      rem  = neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
      case (op_q)
         3'd0:       fix_val = prod[W-1:0];
         3'd1, 3'd2, 3'd3: fix_val = prod[2*W-1:W];
         3'd4, 3'd5: fix_val = quot;
         default:    fix_val = rem;
      endcase
      if (spec_q) fix_val = acc_q[W-1:0];
   end

   // Special cases skip CALC but still pass through FIX so the result lands one edge later.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_start) state_d = special ? S_FIX : S_CALC;
         S_CALC: if (cnt_q == '1) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (i_flush) state_d = S_IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q    <= '0;
         op_q     <= '0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         acc_q    <= '0;
         o_result <= '0;
      end else if (i_flush) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (i_start) begin
               op_q    <= i_op;
               a_mag_q <= a_abs;
               b_mag_q <= b_abs;
               neg_q   <= res_neg;
               spec_q  <= special;
               cnt_q   <= '0;
               if (special)      acc_q <= {{W{1'b0}}, special_val};
               else if (i_op[2]) acc_q <= {{W{1'b0}}, a_abs};
               else              acc_q <= {{W{1'b0}}, b_abs};
            end
            S_CALC: begin
               acc_q <= op_q[2] ? div_next : mul_next;
               cnt_q <= cnt_q + 1'b1;
            end
            S_FIX: o_result <= fix_val;
            default: ;
         endcase
      end
   end

   assign o_busy    = (state_q != S_IDLE);
   assign o_done    = (state_q == S_DONE) & ~i_flush;
   assign o_stall_e = ((state_q == S_IDLE) & i_start & ~i_flush) |
                      (state_q == S_CALC) | (state_q == S_FIX);

endmodule
